// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO: Gray-coded pointers cross through SYNC_STAGES flops; each domain
// reports its own fill level, almost flags and a sticky overflow/underflow flag.
module async_fifo_lvl #(
  parameter int DW          = 16,
  parameter int AW          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 0,
  parameter int AFULL_TH    = (1 << AW) - 2,
  parameter int AEMPTY_TH   = 2
) (
  input  logic          wclk,
  input  logic          wrst,
  input  logic          rclk,
  input  logic          rrst,
  input  logic          wen,
  input  logic [DW-1:0] wdata,
  output logic          wfull,
  output logic          walmost_full,
  output logic [AW:0]   wlevel,
  output logic          woverflow,
  input  logic          ren,
  output logic [DW-1:0] rdata,
  output logic          rempty,
  output logic          ralmost_empty,
  output logic [AW:0]   rlevel,
  output logic          runderflow
);
  localparam logic [AW:0] FULL_LVL   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_TH);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DW-1:0] mem_q [1 << AW];

  logic [AW:0]   wbin_q, wbin_d, wgray_q, wlevel_q, wlevel_d, rbin_sync;
  logic [AW:0]   rgray_sync_q [SYNC_STAGES];
  logic          wfull_q, wfull_d, wafull_q, wafull_d, wovf_q, wacc;

  logic [AW:0]   rbin_q, rbin_d, rgray_q, rlevel_q, rlevel_d, wbin_sync, ravail;
  logic [AW:0]   wgray_sync_q [SYNC_STAGES];
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata_q;
  logic          rempty_q, rempty_d, raempty_q, raempty_d, rudf_q;
  logic          rpop, rload, ov_q, ov_d;

  // Write domain
  always_comb begin
    wacc      = wen && !wfull_q && !wrst;
    rbin_sync = gray2bin(rgray_sync_q[SYNC_STAGES-1]);
    wbin_d    = wbin_q + (AW+1)'(wacc);
    wlevel_d  = wbin_d - rbin_sync;
    wfull_d   = (wlevel_d == FULL_LVL);
    wafull_d  = (wlevel_d >= AFULL_LVL);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rgray_sync_q[i] <= '0;
      end
    end else begin
      wbin_q          <= wbin_d;
      wgray_q         <= bin2gray(wbin_d);
      wlevel_q        <= wlevel_d;
      wfull_q         <= wfull_d;
      wafull_q        <= wafull_d;
      rgray_sync_q[0] <= rgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rgray_sync_q[i] <= rgray_sync_q[i-1];
      end
      if (wen && wfull_q) begin
        wovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (wacc) begin
      mem_q[wbin_q[AW-1:0]] <= wdata;
    end
  end

  // Read domain; rbin counts popped words, so a prefetched head still occupies its slot
  always_comb begin
    rpop      = ren && !rempty_q;
    wbin_sync = gray2bin(wgray_sync_q[SYNC_STAGES-1]);
    ravail    = wbin_sync - rbin_q;
    raddr     = rbin_q[AW-1:0];
    rload     = rpop;
    ov_d      = 1'b0;
    if (FWFT != 0) begin
      raddr = rbin_q[AW-1:0] + AW'(ov_q);
      rload = (!ov_q || rpop) && (ravail != (AW+1)'(ov_q));
      ov_d  = rload || (ov_q && !rpop);
    end
    rbin_d    = rbin_q + (AW+1)'(rpop);
    rlevel_d  = wbin_sync - rbin_d;
    rempty_d  = (rlevel_d == '0);
    raempty_d = (rlevel_d <= AEMPTY_LVL);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q    <= '0;
      rgray_q   <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rudf_q    <= 1'b0;
      ov_q      <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        wgray_sync_q[i] <= '0;
      end
    end else begin
      rbin_q          <= rbin_d;
      rgray_q         <= bin2gray(rbin_d);
      rlevel_q        <= rlevel_d;
      rempty_q        <= rempty_d;
      raempty_q       <= raempty_d;
      ov_q            <= ov_d;
      wgray_sync_q[0] <= wgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        wgray_sync_q[i] <= wgray_sync_q[i-1];
      end
      if (rload) begin
        rdata_q <= mem_q[raddr];
      end
      if (ren && rempty_q) begin
        rudf_q <= 1'b1;
      end
    end
  end

  assign wfull         = wfull_q;
  assign walmost_full  = wafull_q;
  assign wlevel        = wlevel_q;
  assign woverflow     = wovf_q;
  assign rdata         = rdata_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = raempty_q;
  assign rlevel        = rlevel_q;
  assign runderflow    = rudf_q;

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Bench for async_fifo_lvl: a registered-read and an FWFT instance share one stimulus
// stream; a queue model tracks contents and the flag rules are checked every cycle.
`timescale 1ns/100ps
module tb_async_fifo_lvl;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int AFULL = 6;
  localparam int AEMPTY = 2;

  logic wclk = 1'b0;
  logic rclk = 1'b0;
  logic wrst = 1'b1;
  logic rrst = 1'b1;
  logic wen = 1'b0;
  logic ren = 1'b0;
  logic [DW-1:0] wdata = '0;

  logic wfull0, wafull0, wovf0, rempty0, raempty0, rudf0;
  logic wfull1, wafull1, wovf1, rempty1, raempty1, rudf1;
  logic [AW:0] wlevel0, rlevel0, wlevel1, rlevel1;
  logic [DW-1:0] rdata0, rdata1;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] exp0 = '0;

  async_fifo_lvl #(.DW(DW), .AW(AW), .SYNC_STAGES(2), .FWFT(0), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY)) u0 (
    .wclk(wclk), .wrst(wrst), .rclk(rclk), .rrst(rrst),
    .wen(wen), .wdata(wdata), .wfull(wfull0), .walmost_full(wafull0), .wlevel(wlevel0), .woverflow(wovf0),
    .ren(ren), .rdata(rdata0), .rempty(rempty0), .ralmost_empty(raempty0), .rlevel(rlevel0), .runderflow(rudf0)
  );

  async_fifo_lvl #(.DW(DW), .AW(AW), .SYNC_STAGES(2), .FWFT(1), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY)) u1 (
    .wclk(wclk), .wrst(wrst), .rclk(rclk), .rrst(rrst),
    .wen(wen), .wdata(wdata), .wfull(wfull1), .walmost_full(wafull1), .wlevel(wlevel1), .woverflow(wovf1),
    .ren(ren), .rdata(rdata1), .rempty(rempty1), .ralmost_empty(raempty1), .rlevel(rlevel1), .runderflow(rudf1)
  );

  always #5 wclk = ~wclk;
  initial begin
    #1.3;
    forever #13.5 rclk = ~rclk;
  end

  initial begin
    #100us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: contents follow accepted writes/reads exactly as the flags gate them
  always @(posedge wclk) begin
    if (wrst) begin
      q0.delete();
      q1.delete();
    end else if (wen) begin
      if (!wfull0) q0.push_back(wdata);
      if (!wfull1) q1.push_back(wdata);
    end
  end

  always @(posedge rclk) begin
    if (rrst) begin
      exp0 = '0;
      q0.delete();
      q1.delete();
    end else if (ren) begin
      if (!rempty0) begin
        chk("pop_has_data0", 32'(q0.size() > 0), 1);
        if (q0.size() > 0) exp0 = q0.pop_front();
      end
      if (!rempty1) begin
        chk("pop_has_data1", 32'(q1.size() > 0), 1);
        if (q1.size() > 0) void'(q1.pop_front());
      end
    end
  end

  always @(negedge rclk) begin
    if (!rrst && !wrst) begin
      chk("rdata0", 32'(rdata0), 32'(exp0));
      chk("rempty_rule0", 32'(rempty0), 32'(rlevel0 == 0));
      chk("raempty_rule0", 32'(raempty0), 32'(rlevel0 <= AEMPTY));
      chk("rlevel_bound0", 32'(rlevel0 <= q0.size()), 1);
      chk("rempty_rule1", 32'(rempty1), 32'(rlevel1 == 0));
      chk("raempty_rule1", 32'(raempty1), 32'(rlevel1 <= AEMPTY));
      chk("rlevel_bound1", 32'(rlevel1 <= q1.size()), 1);
      if (!rempty1) begin
        chk("head_present1", 32'(q1.size() > 0), 1);
        if (q1.size() > 0) chk("rdata_head1", 32'(rdata1), 32'(q1[0]));
      end
    end
  end

  always @(negedge wclk) begin
    if (!wrst && !rrst) begin
      chk("wfull_rule0", 32'(wfull0), 32'(wlevel0 == DEPTH));
      chk("wafull_rule0", 32'(wafull0), 32'(wlevel0 >= AFULL));
      chk("wlevel_bound0", 32'(wlevel0 >= q0.size() && wlevel0 <= DEPTH), 1);
      chk("wfull_rule1", 32'(wfull1), 32'(wlevel1 == DEPTH));
      chk("wafull_rule1", 32'(wafull1), 32'(wlevel1 >= AFULL));
      chk("wlevel_bound1", 32'(wlevel1 >= q1.size() && wlevel1 <= DEPTH), 1);
    end
  end

  task automatic wr(input logic [DW-1:0] d);
    wen = 1'b1;
    wdata = d;
    @(posedge wclk);
    #1;
    wen = 1'b0;
  endtask

  task automatic rd();
    ren = 1'b1;
    @(posedge rclk);
    #1;
    ren = 1'b0;
  endtask

  task automatic wait_r(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic rst_chk(input string t);
    chk({t, "_wfull0"}, 32'(wfull0), 0);
    chk({t, "_wafull0"}, 32'(wafull0), 0);
    chk({t, "_wlevel0"}, 32'(wlevel0), 0);
    chk({t, "_wovf0"}, 32'(wovf0), 0);
    chk({t, "_rdata0"}, 32'(rdata0), 0);
    chk({t, "_rempty0"}, 32'(rempty0), 1);
    chk({t, "_raempty0"}, 32'(raempty0), 1);
    chk({t, "_rlevel0"}, 32'(rlevel0), 0);
    chk({t, "_rudf0"}, 32'(rudf0), 0);
    chk({t, "_wfull1"}, 32'(wfull1), 0);
    chk({t, "_wlevel1"}, 32'(wlevel1), 0);
    chk({t, "_wovf1"}, 32'(wovf1), 0);
    chk({t, "_rdata1"}, 32'(rdata1), 0);
    chk({t, "_rempty1"}, 32'(rempty1), 1);
    chk({t, "_rlevel1"}, 32'(rlevel1), 0);
    chk({t, "_rudf1"}, 32'(rudf1), 0);
  endtask

  initial begin
    bit found;
    wait_r(5);
    rst_chk("reset");
    wrst = 1'b0;
    rrst = 1'b0;
    repeat (3) @(posedge wclk);
    #1;

    // Fill to full, then one write too many
    for (int i = 1; i <= 8; i++) begin
      wr(16'(i));
      if (i == 5) chk("afull_after5", 32'(wafull0), 0);
      if (i == 6) chk("afull_after6", 32'(wafull0), 1);
      if (i == 7) chk("full_after7", 32'(wfull0), 0);
      if (i == 8) begin
        chk("full_after8", 32'(wfull0), 1);
        chk("wlevel_full", 32'(wlevel0), 8);
        chk("full_after8_fwft", 32'(wfull1), 1);
      end
    end
    chk("ovf_before", 32'(wovf0), 0);
    wr(16'h0009);
    chk("ovf_set0", 32'(wovf0), 1);
    chk("ovf_set1", 32'(wovf1), 1);
    chk("wlevel_after_ovf", 32'(wlevel0), 8);

    // Drain
    wait_r(5);
    chk("rlevel_full", 32'(rlevel0), 8);
    chk("rdata_no_read0", 32'(rdata0), 0);
    chk("fwft_head_first", 32'(rdata1), 16'h0001);
    for (int i = 1; i <= 8; i++) begin
      rd();
      chk("drain_rdata0", 32'(rdata0), 32'(i));
    end
    chk("empty_after_drain0", 32'(rempty0), 1);
    chk("empty_after_drain1", 32'(rempty1), 1);
    chk("rlevel_drained", 32'(rlevel0), 0);
    chk("udf_before", 32'(rudf0), 0);
    rd();
    chk("udf_set0", 32'(rudf0), 1);
    chk("udf_set1", 32'(rudf1), 1);
    chk("rdata_hold_udf", 32'(rdata0), 16'h0008);

    // FWFT visibility of a single word
    repeat (4) @(posedge wclk);
    #1;
    wr(16'hA5A5);
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(posedge rclk);
      #1;
      if (!rempty1) found = 1'b1;
    end
    chk("fwft_visible_4rclk", 32'(found), 1);
    chk("fwft_rdata", 32'(rdata1), 16'hA5A5);
    rd();
    chk("fwft_empty_after_pop", 32'(rempty1), 1);
    chk("reg_rdata_a5a5", 32'(rdata0), 16'hA5A5);
    chk("reg_empty_after_pop", 32'(rempty0), 1);

    // Wrap-around streaming, occupancy held at 4..5
    for (int i = 0; i < 4; i++) wr(16'h1000 + 16'(i));
    wait_r(4);
    for (int i = 4; i < 44; i++) begin
      wr(16'h1000 + 16'(i));
      rd();
    end
    for (int i = 0; i < 4; i++) rd();
    wait_r(4);
    chk("wrap_rlevel_end", 32'(rlevel0), 0);
    chk("wrap_last_word", 32'(rdata0), 16'h102B);
    chk("ovf_sticky", 32'(wovf0), 1);
    chk("udf_sticky", 32'(rudf0), 1);

    // Mid-operation reset while both sides stream
    fork
      begin
        for (int i = 0; i < 12; i++) wr(16'h2000 + 16'(i));
      end
      begin
        repeat (2) @(posedge rclk);
        #1;
        for (int i = 0; i < 4; i++) rd();
      end
      begin
        repeat (6) @(posedge wclk);
        #2;
        wrst = 1'b1;
        rrst = 1'b1;
        wait_r(4);
        rst_chk("midreset");
      end
    join
    wrst = 1'b0;
    rrst = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    wr(16'h1234);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(posedge rclk);
      #1;
      if (!rempty0) found = 1'b1;
    end
    chk("post_reset_visible", 32'(found), 1);
    chk("post_reset_fwft_head", 32'(rdata1), 16'h1234);
    rd();
    chk("post_reset_first_word", 32'(rdata0), 16'h1234);
    wait_r(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
